// File: rtl/md5_lane_dispatch_if.sv
// rtl/md5_lane_dispatch_if.sv - message input and md5 lane bus bundle
//
// Groups the candidate-message handshake and the per-lane md5core bus.
// master: the surrounding environment (producer and lanes).
// slave : md5_lane_dispatch.
//   msg_in / msg_in_valid / msg_in_ready      candidate message handshake
//   lane_msg / lane_msg_valid                 per-lane message and start pulse
//   lane_hash / lane_msg_ret / lane_ret_valid per-lane digest, echoed message, valid
interface md5_lane_dispatch_if #(
  parameter int NUM_LANES = 4,
  parameter int MSG_W     = 152
);
  logic [MSG_W-1:0]           msg_in;
  logic                       msg_in_valid;
  logic                       msg_in_ready;
  logic [NUM_LANES*MSG_W-1:0] lane_msg;
  logic [NUM_LANES-1:0]       lane_msg_valid;
  logic [NUM_LANES*128-1:0]   lane_hash;
  logic [NUM_LANES*MSG_W-1:0] lane_msg_ret;
  logic [NUM_LANES-1:0]       lane_ret_valid;

  modport master (
    output msg_in, msg_in_valid, lane_hash, lane_msg_ret, lane_ret_valid,
    input  msg_in_ready, lane_msg, lane_msg_valid
  );

  modport slave (
    input  msg_in, msg_in_valid, lane_hash, lane_msg_ret, lane_ret_valid,
    output msg_in_ready, lane_msg, lane_msg_valid
  );
endinterface

// File: rtl/md5_lane_dispatch.sv
// rtl/md5_lane_dispatch.sv - round-robin md5 lane dispatcher with target-hash match
//
// Spreads candidate messages over NUM_LANES md5core lanes, compares returned
// digests against target_hash and records the first match.
// Ports:
//   clk, reset (async, active-high), clear (sync restart pulse)
//   target_hash            {a,b,c,d}, held stable while running
//   bus                    md5_lane_dispatch_if.slave (message in + lane bus)
//   match, match_msg, match_lane   first recorded match (sticky until clear)
//   hash_count             digests compared since clear, saturating
//   busy                   work still in flight in the lanes
//   stall_count            only with MD5_LANE_PERF_EN: cycles of valid && !ready
module md5_lane_dispatch #(
  parameter int NUM_LANES = 4,
  parameter int MSG_W     = 152,
  parameter int CNT_W     = 32,
  parameter int OUT_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [127:0]        target_hash,
  md5_lane_dispatch_if.slave  bus,
  output logic                match,
  output logic [MSG_W-1:0]    match_msg,
  output logic [3:0]          match_lane,
  output logic [CNT_W-1:0]    hash_count,
  output logic                busy
`ifdef MD5_LANE_PERF_EN
  ,
  output logic [CNT_W-1:0]    stall_count
`endif
);

  typedef enum logic [1:0] {RUN, MATCHED, FLUSH} state_t;

  // popcount of up to 16 return strobes
  localparam int RC_W = 5;
  localparam int OS_W = OUT_W + RC_W;
  localparam int HS_W = CNT_W + RC_W;

  state_t                     state, state_nx;
  logic [3:0]                 rr_ptr;
  logic [OUT_W-1:0]           outstanding, out_nx;
  logic [OS_W-1:0]            out_sum;
  logic [RC_W-1:0]            ret_cnt;
  logic [HS_W-1:0]            hc_sum;
  logic [CNT_W-1:0]           hc_nx;
  logic                       accept, cmp_en, cnt_en, commit;
  logic [NUM_LANES-1:0]       s1_hit;
  logic [NUM_LANES*MSG_W-1:0] s1_msg;
  logic [3:0]                 hit_lane;
  logic [MSG_W-1:0]           hit_msg;

  assign accept = bus.msg_in_valid && bus.msg_in_ready;
  assign busy   = (outstanding != '0);
  assign commit = cmp_en && (|s1_hit);

  always_comb begin
    ret_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++)
      ret_cnt = ret_cnt + RC_W'(bus.lane_ret_valid[i]);
  end

  // Net in-flight update; returns beyond what is in flight clamp to zero
  // so stray results after reset or a protocol error cannot underflow.
  always_comb begin
    out_sum = OS_W'(outstanding) + OS_W'(accept);
    if (out_sum < OS_W'(ret_cnt))
      out_nx = '0;
    else
      out_nx = OUT_W'(out_sum - OS_W'(ret_cnt));
  end

  always_comb begin
    hc_sum = HS_W'(hash_count) + HS_W'(ret_cnt);
    if (hc_sum > HS_W'({CNT_W{1'b1}}))
      hc_nx = '1;
    else
      hc_nx = CNT_W'(hc_sum);
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = (out_nx != '0) ? FLUSH : RUN;
    end else begin
      case (state)
        RUN:     if (commit) state_nx = MATCHED;
        FLUSH:   if (out_nx == '0) state_nx = RUN;
        default: state_nx = state;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    bus.msg_in_ready = (state == RUN) && !clear;
    cmp_en           = (state == RUN) && !clear;
    cnt_en           = (state != FLUSH) && !clear;
  end

  // Dispatch: lane data is held until the lane is chosen again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.lane_msg       <= '0;
      bus.lane_msg_valid <= '0;
      rr_ptr             <= '0;
    end else begin
      bus.lane_msg_valid <= '0;
      if (clear) begin
        rr_ptr <= '0;
      end else if (accept) begin
        bus.lane_msg[rr_ptr*MSG_W +: MSG_W] <= bus.msg_in;
        bus.lane_msg_valid                  <= NUM_LANES'(1) << rr_ptr;
        rr_ptr <= (rr_ptr == 4'(NUM_LANES-1)) ? 4'd0 : rr_ptr + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) outstanding <= '0;
    else       outstanding <= out_nx;
  end

  // Stage 1: per-lane hit flags; gating with cmp_en drops returns seen
  // outside RUN and invalidates the stage on clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_hit <= '0;
      s1_msg <= '0;
    end else begin
      s1_msg <= bus.lane_msg_ret;
      for (int i = 0; i < NUM_LANES; i++)
        s1_hit[i] <= cmp_en && bus.lane_ret_valid[i] &&
                     (bus.lane_hash[i*128 +: 128] == target_hash);
    end
  end

  // Stage 2 select: walk downwards so the lowest lane index wins.
  always_comb begin
    hit_lane = '0;
    hit_msg  = '0;
    for (int i = NUM_LANES-1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        hit_lane = 4'(i);
        hit_msg  = s1_msg[i*MSG_W +: MSG_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match      <= 1'b0;
      match_msg  <= '0;
      match_lane <= '0;
    end else if (clear) begin
      match      <= 1'b0;
      match_msg  <= '0;
      match_lane <= '0;
    end else if (commit) begin
      match      <= 1'b1;
      match_msg  <= hit_msg;
      match_lane <= hit_lane;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       hash_count <= '0;
    else if (clear)  hash_count <= '0;
    else if (cnt_en) hash_count <= hc_nx;
  end

`ifdef MD5_LANE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (clear)
      stall_count <= '0;
    else if (bus.msg_in_valid && !bus.msg_in_ready && (stall_count != '1))
      stall_count <= stall_count + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_md5_lane_dispatch.sv
// tb/tb_md5_lane_dispatch.sv - scoreboard bench for md5_lane_dispatch
module tb_md5_lane_dispatch;
  localparam int NL = 4;
  localparam int MW = 152;
  localparam int CW = 4;
  localparam int OW = 8;
  localparam logic [127:0] HKEY  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] MAGIC = 128'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0;

  logic           clk = 1'b0;
  logic           reset, clear;
  logic [127:0]   target_hash;
  logic           match;
  logic [MW-1:0]  match_msg;
  logic [3:0]     match_lane;
  logic [CW-1:0]  hash_count;
  logic           busy;
`ifdef MD5_LANE_PERF_EN
  logic [CW-1:0]  stall_count;
`endif

  md5_lane_dispatch_if #(.NUM_LANES(NL), .MSG_W(MW)) bus ();

  md5_lane_dispatch #(.NUM_LANES(NL), .MSG_W(MW), .CNT_W(CW), .OUT_W(OW)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .target_hash (target_hash),
    .bus         (bus),
    .match       (match),
    .match_msg   (match_msg),
    .match_lane  (match_lane),
    .hash_count  (hash_count),
    .busy        (busy)
`ifdef MD5_LANE_PERF_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int lane; logic [MW-1:0] msg; } disp_t;
  typedef struct { int due; int lane; logic [MW-1:0] msg; } ret_t;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    exp_rr = 0;
  int    first_hit_cyc = -1;
  int    lat [NL];
  bit    manual = 1'b0;
  disp_t exp_q [$];
  disp_t obs_q [$];
  ret_t  pend  [$];

  function automatic logic [127:0] hash_of(input logic [MW-1:0] m);
    return m[127:0] ^ HKEY;
  endfunction

  function automatic logic [MW-1:0] mk(input int tag, input logic [127:0] low);
    return {24'(tag), low};
  endfunction

  // One clock: record dispatches, then drive this cycle's lane returns.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NL; i++) begin
      if (bus.lane_msg_valid[i]) begin
        disp_t d;
        ret_t  r;
        d.lane = i;
        d.msg  = bus.lane_msg[i*MW +: MW];
        obs_q.push_back(d);
        if (!manual) begin
          r.due  = cyc + lat[i];
          r.lane = i;
          r.msg  = d.msg;
          pend.push_back(r);
        end
      end
    end
    if (!manual) begin
      bus.lane_ret_valid = '0;
      for (int k = pend.size()-1; k >= 0; k--) begin
        if (pend[k].due == cyc) begin
          bus.lane_ret_valid[pend[k].lane]          = 1'b1;
          bus.lane_msg_ret[pend[k].lane*MW +: MW]   = pend[k].msg;
          bus.lane_hash[pend[k].lane*128 +: 128]    = hash_of(pend[k].msg);
          if (hash_of(pend[k].msg) == target_hash && first_hit_cyc < 0)
            first_hit_cyc = cyc;
          pend.delete(k);
        end
      end
    end
  endtask

  task automatic send(input logic [MW-1:0] m);
    disp_t d;
    bus.msg_in       = m;
    bus.msg_in_valid = 1'b1;
    d.lane = exp_rr;
    d.msg  = m;
    exp_q.push_back(d);
    exp_rr = (exp_rr + 1) % NL;
    step();
  endtask

  task automatic pulse_clear();
    bus.msg_in_valid = 1'b0;
    clear = 1'b1;
    step();
    clear  = 1'b0;
    exp_rr = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && pend.size() > 0; n++) step();
    total++;
    if (pend.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d exp=0", pend.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear = 1'b0;
    bus.msg_in = '0;
    bus.msg_in_valid = 1'b0;
    bus.lane_hash = '0;
    bus.lane_msg_ret = '0;
    bus.lane_ret_valid = '0;
    target_hash = hash_of(mk(0, MAGIC));
    for (int i = 0; i < NL; i++) lat[i] = 65;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    total += 8;
    if (match !== 1'b0) begin bad++; $display("FAIL reset_match got=%0d exp=0", match); end
    if (match_msg !== '0) begin bad++; $display("FAIL reset_match_msg got=%h exp=0", match_msg); end
    if (match_lane !== 4'd0) begin bad++; $display("FAIL reset_match_lane got=%0d exp=0", match_lane); end
    if (hash_count !== '0) begin bad++; $display("FAIL reset_hash_count got=%0d exp=0", hash_count); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", busy); end
    if (bus.lane_msg_valid !== '0) begin bad++; $display("FAIL reset_lane_valid got=%b exp=0", bus.lane_msg_valid); end
    if (bus.lane_msg !== '0) begin bad++; $display("FAIL reset_lane_msg got nonzero exp=0"); end
    if (bus.msg_in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0d exp=1", bus.msg_in_ready); end
  endtask

  task automatic test_no_match();
    disp_t o, e;
    for (int k = 0; k < 10; k++) send(mk(k, 128'(k) + 128'h1000));
    bus.msg_in_valid = 1'b0;
    drain();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL nm_busy_at_last_ret got=%0d exp=1", busy); end
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL nm_busy_after got=%0d exp=0", busy); end
    total++;
    if (obs_q.size() != 10) begin bad++; $display("FAIL nm_dispatch_n got=%0d exp=10", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o.lane !== e.lane || o.msg !== e.msg) begin
        bad++;
        $display("FAIL nm_dispatch got lane=%0d msg=%h exp lane=%0d msg=%h", o.lane, o.msg, e.lane, e.msg);
      end
    end
    exp_q.delete();
    obs_q.delete();
    total += 2;
    if (hash_count !== 4'd10) begin bad++; $display("FAIL nm_hash_count got=%0d exp=10", hash_count); end
    if (match !== 1'b0) begin bad++; $display("FAIL nm_match got=%0d exp=0", match); end
  endtask

  task automatic test_match();
    disp_t o, e;
    logic [MW-1:0] m6;
    pulse_clear();
    total++;
    if (hash_count !== '0) begin bad++; $display("FAIL m_clear_count got=%0d exp=0", hash_count); end
    first_hit_cyc = -1;
    m6 = mk(105, MAGIC);
    for (int k = 0; k < 10; k++) begin
      if (k == 5)      send(m6);
      else if (k == 7) send(mk(107, MAGIC));
      else             send(mk(k + 20, 128'(k) + 128'h2000));
    end
    bus.msg_in_valid = 1'b0;
    for (int n = 0; n < 200 && match !== 1'b1; n++) step();
    total += 5;
    if (match !== 1'b1) begin bad++; $display("FAIL m_match got=%0d exp=1", match); end
    if (cyc - first_hit_cyc != 2) begin bad++; $display("FAIL m_latency got=%0d exp=2", cyc - first_hit_cyc); end
    if (match_lane !== 4'd1) begin bad++; $display("FAIL m_lane got=%0d exp=1", match_lane); end
    if (match_msg !== m6) begin bad++; $display("FAIL m_msg got=%h exp=%h", match_msg, m6); end
    if (bus.msg_in_ready !== 1'b0) begin bad++; $display("FAIL m_ready got=%0d exp=0", bus.msg_in_ready); end
    drain();
    step();
    total += 3;
    if (match_lane !== 4'd1 || match_msg !== m6) begin
      bad++;
      $display("FAIL m_sticky got lane=%0d msg=%h exp lane=1 msg=%h", match_lane, match_msg, m6);
    end
    if (hash_count !== 4'd10) begin bad++; $display("FAIL m_hash_count got=%0d exp=10", hash_count); end
    if (busy !== 1'b0) begin bad++; $display("FAIL m_busy got=%0d exp=0", busy); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o.lane !== e.lane || o.msg !== e.msg) begin
        bad++;
        $display("FAIL m_dispatch got lane=%0d msg=%h exp lane=%0d msg=%h", o.lane, o.msg, e.lane, e.msg);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

`ifdef MD5_LANE_PERF_EN
  task automatic test_perf();
    bus.msg_in = mk(999, 128'h77);
    bus.msg_in_valid = 1'b1;
    repeat (20) step();
    bus.msg_in_valid = 1'b0;
    total += 2;
    if (stall_count !== 4'd15) begin
      // a 4-bit counter saturates before 20 stalled cycles
      bad++;
      $display("FAIL perf_stall got=%0d exp=15", stall_count);
    end
    if (obs_q.size() != 0) begin bad++; $display("FAIL perf_no_dispatch got=%0d exp=0", obs_q.size()); end
    pulse_clear();
    total++;
    if (stall_count !== '0) begin bad++; $display("FAIL perf_clear got=%0d exp=0", stall_count); end
    obs_q.delete();
  endtask
`endif

  task automatic test_simultaneous();
    logic [MW-1:0] m2;
    pulse_clear();
    lat[2] = 66;
    m2 = mk(200, MAGIC);
    send(mk(30, 128'h3000));
    send(mk(31, 128'h3001));
    send(m2);
    send(mk(201, MAGIC));
    bus.msg_in_valid = 1'b0;
    drain();
    step();
    step();
    total += 4;
    if (match !== 1'b1) begin bad++; $display("FAIL sim_match got=%0d exp=1", match); end
    if (match_lane !== 4'd2) begin bad++; $display("FAIL sim_lane got=%0d exp=2", match_lane); end
    if (match_msg !== m2) begin bad++; $display("FAIL sim_msg got=%h exp=%h", match_msg, m2); end
    if (hash_count !== 4'd4) begin bad++; $display("FAIL sim_hash_count got=%0d exp=4", hash_count); end
    lat[2] = 65;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_flush();
    disp_t o, e;
    pulse_clear();
    for (int k = 0; k < 5; k++) send(k == 2 ? mk(300, MAGIC) : mk(40 + k, 128'(k) + 128'h4000));
    bus.msg_in_valid = 1'b0;
    repeat (3) step();
    clear = 1'b1;
    #1;
    total++;
    if (bus.msg_in_ready !== 1'b0) begin bad++; $display("FAIL fl_ready_in_clear got=%0d exp=0", bus.msg_in_ready); end
    step();
    clear = 1'b0;
    exp_rr = 0;
    total += 3;
    if (bus.msg_in_ready !== 1'b0) begin bad++; $display("FAIL fl_ready got=%0d exp=0", bus.msg_in_ready); end
    if (busy !== 1'b1) begin bad++; $display("FAIL fl_busy got=%0d exp=1", busy); end
    if (hash_count !== '0) begin bad++; $display("FAIL fl_count_clear got=%0d exp=0", hash_count); end
    drain();
    total++;
    if (bus.msg_in_ready !== 1'b0) begin bad++; $display("FAIL fl_ready_last_ret got=%0d exp=0", bus.msg_in_ready); end
    step();
    total += 4;
    if (bus.msg_in_ready !== 1'b1) begin bad++; $display("FAIL fl_run got=%0d exp=1", bus.msg_in_ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL fl_busy_end got=%0d exp=0", busy); end
    if (hash_count !== '0) begin bad++; $display("FAIL fl_hash_count got=%0d exp=0", hash_count); end
    if (match !== 1'b0) begin bad++; $display("FAIL fl_match got=%0d exp=0", match); end
    send(mk(50, 128'h5000));
    bus.msg_in_valid = 1'b0;
    step();
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o.lane !== e.lane || o.msg !== e.msg) begin
        bad++;
        $display("FAIL fl_dispatch got lane=%0d msg=%h exp lane=%0d msg=%h", o.lane, o.msg, e.lane, e.msg);
      end
    end
    total++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL fl_dispatch_count leftover obs=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    drain();
    step();
    total++;
    if (hash_count !== 4'd1) begin bad++; $display("FAIL fl_count_resume got=%0d exp=1", hash_count); end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_net_sat();
    int hc_exp = 0;
    pulse_clear();
    manual = 1'b1;
    bus.lane_hash = '0;
    bus.lane_msg_ret = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) send(mk(60 + k, 128'h6000));
      bus.msg_in_valid = 1'b0;
      bus.lane_ret_valid = 4'hF;
      step();
      bus.lane_ret_valid = '0;
      hc_exp = (hc_exp + 4 > 15) ? 15 : hc_exp + 4;
    end
    step();
    total += 2;
    if (hash_count !== 4'(hc_exp)) begin bad++; $display("FAIL ns_count12 got=%0d exp=%0d", hash_count, hc_exp); end
    if (busy !== 1'b0) begin bad++; $display("FAIL ns_idle got=%0d exp=0", busy); end
    for (int k = 0; k < 3; k++) send(mk(70 + k, 128'h7000));
    bus.lane_ret_valid = 4'b0011;
    send(mk(73, 128'h7003));
    bus.msg_in_valid = 1'b0;
    bus.lane_ret_valid = '0;
    hc_exp = (hc_exp + 2 > 15) ? 15 : hc_exp + 2;
    bus.lane_ret_valid = 4'b0100;
    step();
    bus.lane_ret_valid = '0;
    hc_exp = (hc_exp + 1 > 15) ? 15 : hc_exp + 1;
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL ns_net_busy got=%0d exp=1", busy); end
    if (hash_count !== 4'(hc_exp)) begin bad++; $display("FAIL ns_count15 got=%0d exp=%0d", hash_count, hc_exp); end
    bus.lane_ret_valid = 4'b1000;
    step();
    bus.lane_ret_valid = '0;
    hc_exp = (hc_exp + 1 > 15) ? 15 : hc_exp + 1;
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL ns_net_idle got=%0d exp=0", busy); end
    if (hash_count !== 4'(hc_exp)) begin bad++; $display("FAIL ns_sat got=%0d exp=%0d", hash_count, hc_exp); end
    send(mk(80, 128'h8000));
    bus.msg_in_valid = 1'b0;
    bus.lane_ret_valid = 4'b0001;
    step();
    bus.lane_ret_valid = '0;
    hc_exp = (hc_exp + 1 > 15) ? 15 : hc_exp + 1;
    total += 2;
    if (hash_count !== 4'(hc_exp)) begin bad++; $display("FAIL ns_sat_hold got=%0d exp=%0d", hash_count, hc_exp); end
    if (busy !== 1'b0) begin bad++; $display("FAIL ns_final_idle got=%0d exp=0", busy); end
    manual = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_no_match();
    test_match();
`ifdef MD5_LANE_PERF_EN
    test_perf();
`endif
    test_simultaneous();
    test_flush();
    test_net_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
